// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit.
// Holds the RV32I funct3 encodings, the FSM state constants, the byte-lane
// select constants, and a helper that checks whether a funct3 is legal
// for a load or a store.
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Byte lane selects (addr[1:0]) within a little-endian word
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Returns 1 when funct3 is a legal encoding for the given direction.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response and memory-side bus of the load/store unit.
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata  request
//   resp_valid/resp_rdata/resp_err                               response
//   mem_write_enable/mem_read_enable/mem_address/mem_data_in      to memory
//   mem_data_out                                                  from memory
// Modports:
//   slave  - the load/store unit itself
//   master - the environment (execute stage plus data memory)
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational sub-word alignment.
// Ports:
//   funct3     in  3   access type (latched request funct3)
//   lane       in  2   addr[1:0] of the access
//   rdata      in  32  word read from memory (little-endian)
//   wdata      in  32  right-aligned store data
//   load_data  out 32  extracted and sign/zero-extended load result
//   store_data out 32  word to write back (read word merged with wdata)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword, then extend or merge by funct3
  always_comb begin
    byte_sel   = 8'h00;
    half_sel   = 16'h0000;
    load_data  = 32'h0000_0000;
    store_data = rdata;

    case (lane)
      LANE_0:  byte_sel = rdata[7:0];
      LANE_1:  byte_sel = rdata[15:8];
      LANE_2:  byte_sel = rdata[23:16];
      LANE_3:  byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase

    if (lane[1]) begin
      half_sel = rdata[31:16];
    end else begin
      half_sel = rdata[15:0];
    end

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h00_0000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      F3_W:    load_data = rdata;
      default: load_data = 32'h0000_0000;
    endcase

    case (funct3)
      F3_B: begin
        case (lane)
          LANE_0:  store_data = {rdata[31:8], wdata[7:0]};
          LANE_1:  store_data = {rdata[31:16], wdata[7:0], rdata[7:0]};
          LANE_2:  store_data = {rdata[31:24], wdata[7:0], rdata[15:0]};
          LANE_3:  store_data = {wdata[7:0], rdata[23:0]};
          default: store_data = rdata;
        endcase
      end
      F3_H: begin
        if (lane[1]) begin
          store_data = {wdata[15:0], rdata[15:0]};
        end else begin
          store_data = {rdata[31:16], wdata[15:0]};
        end
      end
      F3_W:    store_data = wdata;
      default: store_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for a word-wide, byte-addressed data
// memory. Accepts one load/store at a time, checks it for errors, performs
// word-aligned reads/writes (read-modify-write for SB/SH) and returns a
// one-cycle response.
// Parameters:
//   MEM_BYTES   memory size in bytes; any address >= MEM_BYTES faults
//   RD_LATENCY  cycles read_enable is held before data is captured (1..4)
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    lsu_if.slave: request, response and memory-side signals
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES  = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  localparam logic [31:0] MEM_LIMIT   = 32'(MEM_BYTES);
  localparam logic [1:0]  RD_CNT_INIT = 2'(RD_LATENCY - 1);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [1:0]  rd_cnt;

  // Request fields latched on accept
  logic        wr_l;
  logic [2:0]  f3_l;
  logic [1:0]  lane_l;
  logic [31:0] wdata_l;

  // Registered outputs
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;

  logic        accept;
  logic        err;
  logic        rd_done;
  logic [31:0] load_word;
  logic [31:0] store_word;

  assign accept  = bus.req_valid & req_ready;
  assign rd_done = (state == ST_RD) && (rd_cnt == 2'd0);

  // Request fault check: illegal funct3, misalignment or out-of-range address
  always_comb begin
    err = 1'b0;
    if (!f3_legal(bus.req_write, bus.req_funct3)) begin
      err = 1'b1;
    end else if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
      err = 1'b1;
    end else if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
      err = 1'b1;
    end else if (bus.req_addr >= MEM_LIMIT) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!accept) begin
          next_state = ST_IDLE;
        end else if (err) begin
          next_state = ST_RESP;
        end else if (bus.req_write && (bus.req_funct3 == F3_W)) begin
          next_state = ST_WR;
        end else begin
          // loads and SB/SH all begin with a read
          next_state = ST_RD;
        end
      end
      ST_RD: begin
        if (rd_cnt != 2'd0) begin
          next_state = ST_RD;
        end else if (wr_l) begin
          next_state = ST_WR;
        end else begin
          next_state = ST_RESP;
        end
      end
      ST_WR:   next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3     (f3_l),
    .lane       (lane_l),
    .rdata      (bus.mem_data_out),
    .wdata      (wdata_l),
    .load_data  (load_word),
    .store_data (store_word)
  );

  // State, request latches and registered outputs (enables follow next_state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      rd_cnt           <= 2'd0;
      wr_l             <= 1'b0;
      f3_l             <= 3'b000;
      lane_l           <= 2'b00;
      wdata_l          <= 32'h0000_0000;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0000_0000;
      resp_err         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_address      <= 32'h0000_0000;
      mem_data_in      <= 32'h0000_0000;
    end else begin
      state            <= next_state;
      req_ready        <= (next_state == ST_IDLE);
      resp_valid       <= (next_state == ST_RESP);
      mem_read_enable  <= (next_state == ST_RD);
      mem_write_enable <= (next_state == ST_WR);

      if (accept) begin
        wr_l       <= bus.req_write;
        f3_l       <= bus.req_funct3;
        lane_l     <= bus.req_addr[1:0];
        wdata_l    <= bus.req_wdata;
        rd_cnt     <= RD_CNT_INIT;
        resp_rdata <= 32'h0000_0000;
        resp_err   <= err;
        // a faulting request never touches the memory-side address/data
        if (!err) begin
          mem_address <= {bus.req_addr[31:2], 2'b00};
          if (bus.req_write && (bus.req_funct3 == F3_W)) begin
            mem_data_in <= bus.req_wdata;
          end
        end
      end

      if ((state == ST_RD) && (rd_cnt != 2'd0)) begin
        rd_cnt <= rd_cnt - 2'd1;
      end

      // Capture edge: merge for sub-word stores, extract for loads
      if (rd_done) begin
        if (wr_l) begin
          mem_data_in <= store_word;
        end else begin
          resp_rdata <= load_word;
        end
      end

      if (state == ST_RESP) begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'h0000_0000;
      end
    end
  end

  assign bus.req_ready        = req_ready;
  assign bus.resp_valid       = resp_valid;
  assign bus.resp_rdata       = resp_rdata;
  assign bus.resp_err         = resp_err;
  assign bus.mem_write_enable = mem_write_enable;
  assign bus.mem_read_enable  = mem_read_enable;
  assign bus.mem_address      = mem_address;
  assign bus.mem_data_in      = mem_data_in;

endmodule
